// File: rtl/thermocouple_spi_responder_pkg.sv
// Shared constants, state type and frame packing for the thermocouple SPI responder.
// Frame layout follows the MAX31855 word the reader's SPI master expects.
package thermocouple_pkg;

    localparam int unsigned FRAME_BITS = 32;

    localparam int unsigned TC_MSB     = 31;
    localparam int unsigned TC_LSB     = 18;
    localparam int unsigned FAULT_FLAG = 16;
    localparam int unsigned JT_MSB     = 15;
    localparam int unsigned JT_LSB     = 4;
    localparam int unsigned FAULT_MSB  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    // Reserved bits 17 and 3 stay zero.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [13:0] tc,
        input logic [11:0] jt,
        input logic [2:0]  fault
    );
        logic [FRAME_BITS-1:0] f;
        f                      = '0;
        f[TC_MSB:TC_LSB]       = tc;
        f[FAULT_FLAG]          = |fault;
        f[JT_MSB:JT_LSB]       = jt;
        f[FAULT_MSB:0]         = fault;
        return f;
    endfunction

endpackage

// File: rtl/thermocouple_spi_responder_if.sv
// SPI pin bundle between the thermocouple reader (master) and the sensor-side responder (slave).
interface thermocouple_spi_responder_if;

    logic cs_n;
    logic sclk;
    logic miso;
    logic miso_oe;

    modport master (
        output cs_n,
        output sclk,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  cs_n,
        input  sclk,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/thermocouple_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus a history flop for edge detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Reset to the idle pin level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// Sensor-side SPI responder emulating a MAX31855: snapshots temperatures and faults
// at cs_n fall and shifts the 32-bit frame out MSB first, SPI mode 0.
module thermocouple_spi_responder
    import thermocouple_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    thermocouple_spi_responder_if.slave   spi,
    input  logic [13:0]                   tc_temp_in,
    input  logic [11:0]                   junction_temp_in,
    input  logic [2:0]                    fault_in,
    output logic                          frame_done,
    output logic                          frame_abort
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (spi.cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (spi.sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    state_t                 state_q, state_n;
    logic [FRAME_BITS-1:0]  shift_q, shift_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   miso_q, miso_n;
    logic                   oe_q, oe_n;
    logic                   done_q, done_n;
    logic                   abort_q, abort_n;
    logic [FRAME_BITS-1:0]  frame;

    assign frame = pack_frame(tc_temp_in, junction_temp_in, fault_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            cnt_q   <= cnt_n;
            miso_q  <= miso_n;
            oe_q    <= oe_n;
            done_q  <= done_n;
            abort_q <= abort_n;
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        cnt_n   = cnt_q;
        miso_n  = miso_q;
        oe_n    = oe_q;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state_q)
            IDLE: begin
                miso_n = 1'b0;
                oe_n   = 1'b0;
                if (cs_fall) begin
                    shift_n = frame;
                    miso_n  = frame[FRAME_BITS-1];
                    oe_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // cs_n edges win over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    miso_n  = 1'b0;
                    oe_n    = 1'b0;
                    state_n = IDLE;
                    if (cnt_q == CNT_W'(FRAME_BITS)) done_n  = 1'b1;
                    else                             abort_n = 1'b1;
                end else if (!cs_level && sclk_rise) begin
                    if (cnt_q != CNT_W'(FRAME_BITS)) cnt_n = cnt_q + CNT_W'(1);
                end else if (!cs_level && sclk_fall) begin
                    shift_n = {shift_q[FRAME_BITS-2:0], 1'b0};
                    miso_n  = shift_q[FRAME_BITS-2];
                end
            end
            default: begin
                state_n = IDLE;
                miso_n  = 1'b0;
                oe_n    = 1'b0;
            end
        endcase
    end

    assign spi.miso     = miso_q;
    assign spi.miso_oe  = oe_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Self-checking bench: a mode-0 SPI master reads frames and compares them with an arithmetic reference model.
module tb_thermocouple_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] tc;
    logic [11:0] jt;
    logic [2:0]  fault;
    logic        frame_done;
    logic        frame_abort;

    thermocouple_spi_responder_if spi_bus ();

    thermocouple_spi_responder #(
        .SYNC_STAGES (2),
        .FRAME_BITS  (32)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .spi              (spi_bus.slave),
        .tc_temp_in       (tc),
        .junction_temp_in (jt),
        .fault_in         (fault),
        .frame_done       (frame_done),
        .frame_abort      (frame_abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_both = 0;
    int half = 6;
    logic [63:0] last_rx;

    always @(posedge clk) begin
        #1;
        if (frame_done)                n_done++;
        if (frame_abort)               n_abort++;
        if (frame_done && frame_abort) n_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference word from field weights: tc * 2^18, fault summary * 2^16, jt * 2^4, fault flags.
    function automatic logic [31:0] model_frame(input longint t, input longint j, input longint f);
        longint w;
        w = t * 262144 + ((f != 0) ? 65536 : 0) + j * 16 + f;
        return w[31:0];
    endfunction

    task automatic spi_read(input string tag, input int nbits, input int change_at,
                            input logic [13:0] change_val, output logic [63:0] rx);
        rx = '0;
        spi_bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        check({tag, "_oe_on"}, 64'(spi_bus.miso_oe), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            repeat (half) @(negedge clk);
            rx = {rx[62:0], spi_bus.miso};
            spi_bus.sclk = 1'b1;
            if (i + 1 == change_at) tc = change_val;
            repeat (half) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_oe_hold"}, 64'(spi_bus.miso_oe), 64'd1);
        @(negedge clk);
        check({tag, "_oe_off"}, 64'(spi_bus.miso_oe), 64'd0);
        check({tag, "_miso_off"}, 64'(spi_bus.miso), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int nbits, input int change_at,
                             input logic [13:0] change_val);
        logic [31:0] exp_word;
        logic [63:0] exp_stream;
        logic [63:0] rx;
        exp_word = model_frame(longint'(tc), longint'(jt), longint'(fault));
        exp_stream = '0;
        for (int i = 0; i < nbits; i++)
            exp_stream = {exp_stream[62:0], (i < 32) ? exp_word[31 - i] : 1'b0};
        n_done = 0;
        n_abort = 0;
        spi_read(tag, nbits, change_at, change_val, rx);
        last_rx = rx;
        check({tag, "_data"},  rx, exp_stream);
        check({tag, "_done"},  64'(n_done),  (nbits >= 32) ? 64'd1 : 64'd0);
        check({tag, "_abort"}, 64'(n_abort), (nbits >= 32) ? 64'd0 : 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        spi_bus.cs_n = 1'b1;
        spi_bus.sclk = 1'b0;
        tc = 14'h0190;
        jt = 12'h190;
        fault = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_miso",  64'(spi_bus.miso),    64'd0);
        check("rst_oe",    64'(spi_bus.miso_oe), 64'd0);
        check("rst_done",  64'(frame_done),      64'd0);
        check("rst_abort", 64'(frame_abort),     64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame("t1", 32, 0, 14'h0);
        check("t1_const", last_rx, 64'h0000_0000_0640_1900);

        fault = 3'b001;
        run_frame("t2", 32, 0, 14'h0);
        check("t2_const", last_rx, 64'h0000_0000_0641_1901);

        fault = 3'b000;
        run_frame("t3", 32, 5, 14'h3FFC);
        check("t3_const", last_rx, 64'h0000_0000_0640_1900);
        run_frame("t3_next", 32, 0, 14'h0);
        check("t3_tc", 64'(last_rx[31:18]), 64'h3FFC);

        run_frame("t4", 12, 0, 14'h0);
        run_frame("t5", 40, 0, 14'h0);

        // Reset part-way through a frame: link must drop with no pulse.
        tc = 14'h1234;
        jt = 12'hABC;
        fault = 3'b110;
        n_done = 0;
        n_abort = 0;
        spi_bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            repeat (half) @(negedge clk);
            spi_bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_bus.sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spi_bus.cs_n = 1'b1;
        @(negedge clk);
        check("t6_miso", 64'(spi_bus.miso),    64'd0);
        check("t6_oe",   64'(spi_bus.miso_oe), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_pulse", 64'(n_done + n_abort), 64'd0);
        jt = 12'h5A5;
        run_frame("t6_after", 32, 0, 14'h0);

        for (int k = 0; k < 12; k++) begin
            int nb;
            int ch;
            tc    = 14'($urandom);
            jt    = 12'($urandom);
            fault = 3'($urandom);
            half  = $urandom_range(4, 9);
            nb    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 32;
            ch    = $urandom_range(0, nb);
            run_frame($sformatf("rnd%0d", k), nb, ch, 14'($urandom));
        end

        check("pulse_overlap", 64'(n_both), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/thermocouple_spi_responder.md
Name: thermocouple_spi_responder

Overview:
- SPI responder (sensor side) for the thermocouple interface. It models a MAX31855-style cold-junction-compensated converter.
- It packs a thermocouple temperature, a junction temperature and fault flags into the 32-bit frame that the thermocouple reader's SPI master expects, then shifts that frame out on MISO.
- Used in system-level simulation and formal harnesses as the far end of the reader, and on boards as a sensor emulator.
- All logic runs in the system clock domain. The SPI pins are oversampled.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on cs_n and sclk (minimum 2).
- FRAME_BITS, 32, frame length in bits. Fixed by the protocol; only 32 is supported.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, CPOL=0, asynchronous to clk.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  MISO output enable; 1 only while selected.
- tc_temp_in  input  14  thermocouple temperature, signed, 0.25 C/LSB.
- junction_temp_in  input  12  junction temperature, signed, 0.0625 C/LSB.
- fault_in  input  3  {SCV, SCG, OC} fault flags.
- frame_done  output  1  one-cycle pulse: a complete frame was read.
- frame_abort  output  1  one-cycle pulse: cs_n deasserted mid-frame.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - Outputs: miso=0, miso_oe=0, frame_done=0, frame_abort=0.
  - Internal: state=IDLE, shift_reg=0, bit_cnt=0.
  - Synchronizer flops reset to the idle pin levels: cs_n=1, sclk=0.
- Reset mid-frame: abandon the frame immediately. No frame_done or frame_abort pulse is produced.
- Edge detection:
  - Edges are detected by comparing the synchronized signal with its one-cycle history.
  - Outputs react SYNC_STAGES+1 clk cycles after a pin transition.
- Frame layout, captured at cs_n fall:
  - [31:18]=tc_temp_in
  - [17]=0
  - [16]=|fault_in
  - [15:4]=junction_temp_in
  - [3]=0
  - [2:0]=fault_in
- The frame is snapshotted at cs_n fall. Input changes during a frame do not affect the frame in flight.
- State IDLE:
  - miso_oe=0, miso=0.
  - On a cs_n falling edge: load shift_reg with the frame, set miso=frame[31], miso_oe=1, bit_cnt=0, go to SHIFT.
- State SHIFT:
  - On an sclk rising edge (master samples): bit_cnt = bit_cnt+1, saturating at 32.
  - On an sclk falling edge: shift shift_reg left with 0 fill; miso = new shift_reg[31].
  - After 32 bits have been presented, miso stays 0.
  - On a cs_n rising edge: miso_oe=0, miso=0, go to IDLE.
    - If bit_cnt==32, pulse frame_done for 1 cycle.
    - Otherwise pulse frame_abort for 1 cycle.
- Simultaneous detected edges: cs_n edges take priority; an sclk edge in the same cycle is ignored.
- An sclk activity while cs_n is high is ignored.
- Extra clocks beyond 32 read zeros. bit_cnt stays at 32.
- A further cs_n fall while in IDLE starts a fresh frame with a new snapshot.
- frame_done and frame_abort are mutually exclusive and never asserted for more than 1 cycle.
- State encoding: 2 bits. Unused encodings return to IDLE on the next cycle with miso_oe=0.

Decomposition:
- Package thermocouple_pkg holds:
  - FRAME_BITS
  - field position constants: TC_MSB=31, TC_LSB=18, FAULT_FLAG=16, JT_MSB=15, JT_LSB=4
  - state enum {IDLE, SHIFT}
  - a frame-pack function
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus history flop. Instantiated once per pin, reset value as a parameter. Outputs: level, rise, fall.

Test Plan:
1. Reset, then tc=14'h0190, jt=12'h190, fault=0. Drive a 32-clock mode-0 read. The master must sample 32'h0640_1900, then frame_done pulses once after cs_n rises.
2. fault_in=3'b001 with the same temperatures → the master samples 32'h0641_1901 (bits 16 and 0 set).
3. Change tc_temp_in to 14'h3FFC after the 5th sclk rise → the frame still reads 32'h0640_1900. The next frame reads tc field 14'h3FFC.
4. Raise cs_n after 12 sclk rises → frame_abort pulses once, frame_done stays 0, miso_oe=0 within SYNC_STAGES+1 cycles.
5. Issue 40 sclk pulses in one frame → bits 32–39 read 0, and frame_done pulses at cs_n rise.
6. Assert rst mid-SHIFT (bit 10) → the next cycle shows miso=0 and miso_oe=0 with no pulse. A subsequent full read returns the current inputs.
